// File: rtl/alu8_registered.sv
// ---------------------------------------------------------------------------
// alu8_registered
//   8-bit ALU with one register bank on its outputs. One operation is accepted
//   every cycle. Its result and status flags appear one clock edge after the
//   operands and op code are sampled.
//
// Ports
//   clk_i        system clock; all state updates on the rising edge
//   rst_ni       synchronous active-low reset; clears every output register
//   a_i          operand A (unsigned)
//   b_i          operand B (unsigned); low bits give the shift amount for shifts
//   op_code_i    operation select:
//                  000 ADD, 001 SUB, 010 AND, 011 OR,
//                  100 XOR, 101 CMP, 110 SRL, 111 SLL
//   out_o        registered result
//   carry_out_o  registered carry (ADD) or borrow (SUB, CMP); 0 otherwise
//   c_flag_o     registered compare flag, set when a >= b (CMP only)
//   zero_flag_o  registered flag, set when the registered result is zero
// ---------------------------------------------------------------------------
module alu8_registered #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_code_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_out_o,
  output logic             c_flag_o,
  output logic             zero_flag_o
);

  localparam int ShW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpCmp = 3'b101,
    OpSrl = 3'b110,
    OpSll = 3'b111
  } op_e;

  op_e             op;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  dif;
  logic [ShW-1:0]  shamt;

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             cflag_d, cflag_q;
  logic             zero_d, zero_q;

  assign op    = op_e'(op_code_i);
  assign shamt = b_i[ShW-1:0];

  // Widening to WIDTH+1 bits lets the top bit act as the carry for ADD.
  // For SUB and CMP it acts as the borrow, which is set exactly when a < b.
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};

  // Operation decode. Every op code has an arm, so no X can reach the
  // registers. Carry and compare flags default to 0 for the ops that do not
  // define them.
  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    cflag_d = 1'b0;
    case (op)
      OpAdd: begin
        out_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      OpSub: begin
        out_d   = dif[WIDTH-1:0];
        carry_d = dif[WIDTH];
      end
      OpAnd: out_d = a_i & b_i;
      OpOr:  out_d = a_i | b_i;
      OpXor: out_d = a_i ^ b_i;
      OpCmp: begin
        out_d   = dif[WIDTH-1:0];
        carry_d = dif[WIDTH];
        cflag_d = ~dif[WIDTH];
      end
      OpSrl: out_d = a_i >> shamt;
      OpSll: out_d = a_i << shamt;
      default: out_d = '0;
    endcase
    zero_d = (out_d == '0);
  end

  // Output register bank. Reset wins over any operation, and it clears
  // zero_flag as well, even though the cleared result is zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      cflag_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      cflag_q <= cflag_d;
      zero_q  <= zero_d;
    end
  end

  assign out_o       = out_q;
  assign carry_out_o = carry_q;
  assign c_flag_o    = cflag_q;
  assign zero_flag_o = zero_q;

endmodule

// File: tb/tb_alu8_registered.sv
// ---------------------------------------------------------------------------
// tb_alu8_registered
//   Self-checking bench for alu8_registered. It applies directed vectors and
//   randomized vectors, including resets in the middle of the stream. Every
//   registered output is compared against a behavioural model that uses
//   plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu8_registered;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_code_i;
  logic [7:0] out_o;
  logic       carry_out_o;
  logic       c_flag_o;
  logic       zero_flag_o;

  int checkCount = 0;
  int errorCount = 0;

  // Values the model predicted for the most recent edge.
  logic [7:0] expOut;
  logic       expCo, expCf, expZ;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] out;
  } vec_t;

  vec_t dirVecs[16];

  alu8_registered #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_code_i   (op_code_i),
    .out_o       (out_o),
    .carry_out_o (carry_out_o),
    .c_flag_o    (c_flag_o),
    .zero_flag_o (zero_flag_o)
  );

  // Free-running clock with a 10 time unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model. It computes results with unbounded integer arithmetic
  // and reduces them modulo 256. Shifts are written as divide and multiply
  // by powers of two.
  function automatic void modelAlu(input int a, input int b, input int op,
                                   input bit rstn, output logic [7:0] res,
                                   output logic co, output logic cf,
                                   output logic z);
    int r;
    int sh;
    r  = 0;
    co = 1'b0;
    cf = 1'b0;
    sh = b % 8;
    case (op)
      0: begin r = a + b; co = (r > 255); end
      1: begin r = a - b; co = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a - b; co = (a < b); cf = (a >= b); end
      6: r = a / (1 << sh);
      7: r = a * (1 << sh);
      default: r = 0;
    endcase
    r   = ((r % 256) + 256) % 256;
    res = 8'(r);
    z   = (r == 0);
    if (!rstn) begin
      res = 8'h00;
      co  = 1'b0;
      cf  = 1'b0;
      z   = 1'b0;
    end
  endfunction

  // Single comparison point. Every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %02h expected %02h (t=%0t)", tag, observed,
               expected, $time);
    end
  endtask

  // Drive one operation at the falling edge, let the rising edge capture it,
  // then compare all four outputs against the model just after that edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic rstn,
                               input string tag);
    @(negedge clk_i);
    a_i       = a;
    b_i       = b;
    op_code_i = op;
    rst_ni    = rstn;
    modelAlu(int'(a), int'(b), int'(op), rstn, expOut, expCo, expCf, expZ);
    @(posedge clk_i);
    #1;
    checkOutput({tag, ".out"}, out_o, expOut);
    checkOutput({tag, ".co"}, {7'd0, carry_out_o}, {7'd0, expCo});
    checkOutput({tag, ".cf"}, {7'd0, c_flag_o}, {7'd0, expCf});
    checkOutput({tag, ".z"}, {7'd0, zero_flag_o}, {7'd0, expZ});
  endtask

  initial begin
    dirVecs[0]  = '{8'h07, 8'h05, 3'b000, 8'h0C};
    dirVecs[1]  = '{8'h07, 8'h05, 3'b001, 8'h02};
    dirVecs[2]  = '{8'h0F, 8'h05, 3'b001, 8'h0A};
    dirVecs[3]  = '{8'h07, 8'h03, 3'b000, 8'h0A};
    dirVecs[4]  = '{8'hFF, 8'h01, 3'b000, 8'h00};
    dirVecs[5]  = '{8'h03, 8'h05, 3'b001, 8'hFE};
    dirVecs[6]  = '{8'h67, 8'h45, 3'b010, 8'h45};
    dirVecs[7]  = '{8'h05, 8'h55, 3'b011, 8'h55};
    dirVecs[8]  = '{8'h47, 8'h25, 3'b100, 8'h62};
    dirVecs[9]  = '{8'h3C, 8'h3C, 3'b100, 8'h00};
    dirVecs[10] = '{8'h07, 8'h05, 3'b101, 8'h02};
    dirVecs[11] = '{8'h07, 8'h09, 3'b101, 8'hFE};
    dirVecs[12] = '{8'h07, 8'h07, 3'b101, 8'h00};
    dirVecs[13] = '{8'h04, 8'h05, 3'b110, 8'h00};
    dirVecs[14] = '{8'h07, 8'h01, 3'b111, 8'h0E};
    dirVecs[15] = '{8'h81, 8'h08, 3'b111, 8'h81};

    a_i       = 8'h00;
    b_i       = 8'h00;
    op_code_i = 3'b000;
    rst_ni    = 1'b0;

    $display("[TB] reset with arbitrary inputs");
    // The ADD/FF/01 vector would set carry and zero if it were not in reset.
    applyStimulus(8'hFF, 8'h01, 3'b000, 1'b0, "rst0");
    applyStimulus(8'($urandom), 8'($urandom), 3'($urandom), 1'b0, "rst1");

    $display("[TB] directed vectors, back to back");
    foreach (dirVecs[i]) begin
      applyStimulus(dirVecs[i].a, dirVecs[i].b, dirVecs[i].op, 1'b1,
                    $sformatf("dir%0d", i));
      checkOutput($sformatf("dir%0d.spec", i), out_o, dirVecs[i].out);
    end

    $display("[TB] outputs hold while inputs change between edges");
    applyStimulus(8'h07, 8'h05, 3'b101, 1'b1, "holdSetup");
    a_i       = 8'h3C;
    b_i       = 8'h3C;
    op_code_i = 3'b100;
    #3;
    checkOutput("hold.out", out_o, expOut);
    checkOutput("hold.cf", {7'd0, c_flag_o}, {7'd0, expCf});
    checkOutput("hold.z", {7'd0, zero_flag_o}, {7'd0, expZ});

    $display("[TB] reset mid-stream, then resume");
    applyStimulus(8'h10, 8'h20, 3'b001, 1'b1, "midPre");
    applyStimulus(8'hFF, 8'h01, 3'b000, 1'b0, "midRst");
    applyStimulus(8'h07, 8'h09, 3'b101, 1'b1, "midPost");

    $display("[TB] randomized stream with occasional resets");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 19) != 0), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
